// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler: station allocator plus round-robin issue of ready stations to the FUs
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   mispredicted        - flush; suppresses allocation and new grants, clears pend
//   rs_busy, rs_ready   - per-station busy and operands-valid bits
//   alloc_req           - dispatch wants a station this cycle
//   fu_ready            - per-FU ready to accept an issue at the next edge
//   rs_dest             - free station index for dispatch, 3'b111 when none/no request
//   alloc_stall         - request pending with no free station
//   issue_valid/sel     - registered issue per FU, sel[2k+1:2k] is FU k's station
//   consumed_bus        - registered pulse clearing the issued stations
module rs_issue_scheduler #(
    parameter int NUM_FU = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mispredicted,
    input  logic [3:0]            rs_busy,
    input  logic [3:0]            rs_ready,
    input  logic                  alloc_req,
    input  logic [NUM_FU-1:0]     fu_ready,
    output logic [2:0]            rs_dest,
    output logic                  alloc_stall,
    output logic [NUM_FU-1:0]     issue_valid,
    output logic [2*NUM_FU-1:0]   issue_sel,
    output logic [3:0]            consumed_bus
);
    logic [1:0]          rr_ptr;
    logic [3:0]          pend;
    logic [3:0]          free;
    logic [3:0]          elig;
    logic [3:0]          grant_mask;
    logic [2:0]          lowest_free;
    logic [1:0]          idx;
    logic [1:0]          first_idx;
    logic [1:0]          second_idx;
    logic                first_found;
    logic                second_found;
    logic [1:0]          last_idx;
    logic [NUM_FU-1:0]   g_valid;
    logic [2*NUM_FU-1:0] g_sel;

    // a station being consumed is not free: its reset beats a same-cycle write
    assign free        = ~rs_busy & ~consumed_bus;
    assign elig        = rs_busy & rs_ready & ~pend;
    assign lowest_free = free[0] ? 3'd0 : free[1] ? 3'd1 : free[2] ? 3'd2 : free[3] ? 3'd3 : 3'b111;
    assign rs_dest     = (alloc_req && !mispredicted) ? lowest_free : 3'b111;
    assign alloc_stall = alloc_req & ~|free & ~mispredicted;

    // first and second eligible stations, searching upward from rr_ptr with wrap
    always_comb begin
        first_found  = 1'b0;
        second_found = 1'b0;
        first_idx    = 2'd0;
        second_idx   = 2'd0;
        idx          = 2'd0;
        for (int j = 0; j < 4; j++) begin
            idx = rr_ptr + 2'(j);
            if (elig[idx] && !first_found) begin
                first_found = 1'b1;
                first_idx   = idx;
            end else if (elig[idx] && !second_found) begin
                second_found = 1'b1;
                second_idx   = idx;
            end
        end
    end

    assign g_valid[0]  = fu_ready[0] & first_found & ~mispredicted;
    assign g_sel[1:0]  = first_idx;

    generate
        if (NUM_FU == 2) begin : g_two
            // FU1 takes the next station after FU0's, or the first one when FU0 is busy
            assign g_valid[1] = fu_ready[1] & ~mispredicted & (fu_ready[0] ? second_found : first_found);
            assign g_sel[3:2] = fu_ready[0] ? second_idx : first_idx;
            assign last_idx   = g_valid[1] ? g_sel[3:2] : g_sel[1:0];
        end else begin : g_one
            assign last_idx = g_sel[1:0];
        end
    endgenerate

    always_comb begin
        grant_mask = 4'b0000;
        for (int k = 0; k < NUM_FU; k++)
            grant_mask = grant_mask | (g_valid[k] ? (4'b0001 << g_sel[2*k +: 2]) : 4'b0000);
    end

    // pend covers the gap until the station's busy bit is seen low
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr       <= 2'd0;
            pend         <= 4'b0000;
            issue_valid  <= '0;
            issue_sel    <= '0;
            consumed_bus <= 4'b0000;
        end else begin
            pend         <= mispredicted ? 4'b0000 : (pend & rs_busy) | grant_mask;
            issue_valid  <= g_valid;
            issue_sel    <= g_sel;
            consumed_bus <= grant_mask;
            if (|g_valid)
                rr_ptr <= last_idx + 2'd1;
        end
    end
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// tb_rs_issue_scheduler: directed self-checking bench for rs_issue_scheduler
module tb_rs_issue_scheduler;
    logic       clk = 1'b0;
    logic       reset;
    logic       mispredicted;
    logic [3:0] rs_busy;
    logic [3:0] rs_ready;
    logic       alloc_req;
    logic [1:0] fu_ready;
    logic [2:0] rs_dest;
    logic       alloc_stall;
    logic [1:0] issue_valid;
    logic [3:0] issue_sel;
    logic [3:0] consumed_bus;
    int         n_tests = 0;
    int         n_fail  = 0;

    rs_issue_scheduler #(.NUM_FU(2)) dut (
        .clk(clk),
        .reset(reset),
        .mispredicted(mispredicted),
        .rs_busy(rs_busy),
        .rs_ready(rs_ready),
        .alloc_req(alloc_req),
        .fu_ready(fu_ready),
        .rs_dest(rs_dest),
        .alloc_stall(alloc_stall),
        .issue_valid(issue_valid),
        .issue_sel(issue_sel),
        .consumed_bus(consumed_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; mispredicted = 1'b0; rs_busy = 4'b0000; rs_ready = 4'b0000;
        alloc_req = 1'b0; fu_ready = 2'b11;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_valid", 32'(issue_valid), 32'd0);
        chk("rst_sel", 32'(issue_sel), 32'd0);
        chk("rst_consumed", 32'(consumed_bus), 32'd0);
        chk("rst_ptr", 32'(dut.rr_ptr), 32'd0);
        chk("rst_pend", 32'(dut.pend), 32'd0);
        chk("rst_dest", 32'(rs_dest), 32'd7);
        chk("rst_stall", 32'(alloc_stall), 32'd0);

        alloc_req = 1'b1; #1;
        chk("alloc_idle_dest", 32'(rs_dest), 32'd0);
        chk("alloc_idle_stall", 32'(alloc_stall), 32'd0);
        rs_busy = 4'b0111; #1;
        chk("alloc_3_dest", 32'(rs_dest), 32'd3);
        rs_busy = 4'b1111; #1;
        chk("alloc_full_dest", 32'(rs_dest), 32'd7);
        chk("alloc_full_stall", 32'(alloc_stall), 32'd1);
        alloc_req = 1'b0; rs_busy = 4'b0000;

        // stations 1 and 3 ready, pointer at 0
        step();
        rs_busy = 4'b1010; rs_ready = 4'b1010;
        step();
        chk("rr13_valid", 32'(issue_valid), 32'd3);
        chk("rr13_sel", 32'(issue_sel), 32'hD);
        chk("rr13_consumed", 32'(consumed_bus), 32'hA);
        chk("rr13_ptr", 32'(dut.rr_ptr), 32'd0);
        chk("rr13_pend", 32'(dut.pend), 32'hA);
        step();
        chk("rr13_no_reissue", 32'(issue_valid), 32'd0);
        rs_busy = 4'b0000; rs_ready = 4'b0000;
        step();
        chk("rr13_pend_clr", 32'(dut.pend), 32'd0);

        // all four held ready
        rs_busy = 4'b1111; rs_ready = 4'b1111;
        step();
        chk("all_p1_sel", 32'(issue_sel), 32'h4);
        chk("all_p1_consumed", 32'(consumed_bus), 32'h3);
        chk("all_p1_ptr", 32'(dut.rr_ptr), 32'd2);
        step();
        chk("all_p2_sel", 32'(issue_sel), 32'hE);
        chk("all_p2_consumed", 32'(consumed_bus), 32'hC);
        chk("all_p2_ptr", 32'(dut.rr_ptr), 32'd0);
        rs_busy = 4'b1100;
        step();
        chk("all_gap_valid", 32'(issue_valid), 32'd0);
        chk("all_gap_consumed", 32'(consumed_bus), 32'd0);
        rs_busy = 4'b0011;
        step();
        chk("all_p3_sel", 32'(issue_sel), 32'h4);
        chk("all_p3_consumed", 32'(consumed_bus), 32'h3);
        rs_busy = 4'b0000; rs_ready = 4'b0000;
        step();
        step();

        // FU0 not ready, only station 2 ready, pointer at 2
        fu_ready = 2'b10; rs_busy = 4'b0100; rs_ready = 4'b0100;
        step();
        chk("fu1_valid", 32'(issue_valid), 32'd2);
        chk("fu1_sel", 32'(issue_sel[3:2]), 32'd2);
        chk("fu1_consumed", 32'(consumed_bus), 32'h4);
        chk("fu1_ptr", 32'(dut.rr_ptr), 32'd3);
        fu_ready = 2'b11; rs_busy = 4'b0000; rs_ready = 4'b0000;
        step();
        step();

        // station 0 consumed while dispatch wants a station
        rs_busy = 4'b0011; rs_ready = 4'b0001;
        step();
        chk("realloc_consumed", 32'(consumed_bus), 32'h1);
        rs_busy = 4'b0010; rs_ready = 4'b0000; alloc_req = 1'b1; #1;
        chk("realloc_t1_dest", 32'(rs_dest), 32'd2);
        step();
        chk("realloc_t2_dest", 32'(rs_dest), 32'd0);
        alloc_req = 1'b0; rs_busy = 4'b0000;
        step();
        step();
        chk("flush_pre_ptr", 32'(dut.rr_ptr), 32'd1);

        // flush the same cycle stations 0 and 1 become eligible
        rs_busy = 4'b0011; rs_ready = 4'b0011; mispredicted = 1'b1; alloc_req = 1'b1; #1;
        chk("flush_dest", 32'(rs_dest), 32'd7);
        chk("flush_stall", 32'(alloc_stall), 32'd0);
        step();
        mispredicted = 1'b0; alloc_req = 1'b0;
        chk("flush_valid", 32'(issue_valid), 32'd0);
        chk("flush_consumed", 32'(consumed_bus), 32'd0);
        chk("flush_pend", 32'(dut.pend), 32'd0);
        chk("flush_ptr", 32'(dut.rr_ptr), 32'd1);
        step();
        chk("post_flush_sel", 32'(issue_sel), 32'h1);
        chk("post_flush_consumed", 32'(consumed_bus), 32'h3);
        chk("post_flush_ptr", 32'(dut.rr_ptr), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rs_issue_scheduler.md
# rs_issue_scheduler

Issue scheduler and allocator for the four reservation stations. Each cycle it gives a free station to the dispatch stage, or stalls dispatch. It picks up to two operand-ready stations in round-robin order and issues them to the two functional units. For each issue it pulses the matching `consumed_bus` bit, which clears that station. It sits between dispatch and the reservation stations on the input side, and between the reservation stations and the ALU/branch functional units on the output side.

## Interface
- `NUM_FU`, 2: number of functional units. Supported values are 1 and 2.
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high.
- `mispredicted` input 1: flush. Active the same cycle the reservation stations flush.
- `rs_busy` input 4: busy bit of each station.
- `rs_ready` input 4: `valid_operands` of each station. This signal is already registered.
- `alloc_req` input 1: dispatch wants a station this cycle.
- `fu_ready` input NUM_FU: functional unit k can accept an issue at the next clock edge.
- `rs_dest` output 3: station index 0–3 written this cycle; 3'b111 means no write.
- `alloc_stall` output 1: `alloc_req` is high and no station is free.
- `issue_valid` output NUM_FU: registered; FU k must start an operation this cycle.
- `issue_sel` output 2*NUM_FU: registered; bits [2k+1:2k] give the station index issued to FU k.
- `consumed_bus` output 4: registered one-hot-per-FU pulse; it clears the issued stations at the end of this cycle.

## Operation
- **Allocation (combinational):**
  - `free[i] = ~rs_busy[i] & ~consumed_bus[i]`. The consumed bit is excluded because station reset has priority over a write.
  - `rs_dest` is the lowest-index free station when `alloc_req` is high and `mispredicted` is low. Otherwise `rs_dest` is 3'b111.
  - `alloc_stall = alloc_req & ~|free & ~mispredicted`.
- **Eligibility:** `elig[i] = rs_busy[i] & rs_ready[i] & ~pend[i]`.
  - `pend[i]` sets when station i is granted.
  - `pend[i]` clears in the first cycle `rs_busy[i]` is observed low.
  - This prevents re-issuing a station whose clear is still in flight.
- **Selection:**
  - Start from the 2-bit pointer `rr_ptr` and search upward with wrap-around.
  - The first eligible station goes to FU0 if `fu_ready[0]` is high.
  - The next eligible station (strictly after the first, still wrapping) goes to FU1 if `fu_ready[1]` is high.
  - If FU0 is not ready, the first eligible station goes to FU1.
  - A station is never granted to two FUs.
- **Pointer update:** `rr_ptr` becomes (last granted index + 1) mod 4. It holds when nothing is granted.
- **Registering grants:** grants are registered. In the next cycle:
  - `issue_valid[k]` is high and `issue_sel` carries the index.
  - `consumed_bus[idx]` pulses for exactly one cycle.
- **Flush (`mispredicted` high):**
  - No new grant is registered.
  - `pend` clears to 0.
  - `issue_valid` and `consumed_bus` go to 0 at the next edge.
  - `rr_ptr` is held.
  - An issue already visible in the flush cycle completes on the outputs; the FU squashes it by ROB.
- **Reset:** `rr_ptr` = 0, `pend` = 0, `issue_valid` = 0, `issue_sel` = 0, `consumed_bus` = 0. With `alloc_req` low, `rs_dest` = 3'b111.

## Timing
- **Allocation:** zero latency. The station captures at the edge that ends the cycle in which `rs_dest` is driven, and `rs_busy` rises one cycle later.
- **Issue latency:**
  - Cycle t: `elig` and `fu_ready` are sampled.
  - Cycle t+1: `issue_valid` and `consumed_bus` are high.
  - Cycle t+2: the station's `rs_busy` reads 0 and `pend` clears that cycle.
- **Re-allocation:** a station consumed in cycle t+1 is not allocatable in t+1. It is allocatable from t+2.
- **Throughput:** up to NUM_FU issues per cycle, with back-to-back issue from different stations.
- **Simultaneous events:**
  - Allocation and issue to different stations in the same cycle are independent.
  - If `reset` and `mispredicted` are both high, `reset` wins.

## Test plan
- Reset, then `alloc_req`=1 with all stations idle → `rs_dest`=0, `alloc_stall`=0. Stations 0–2 busy → `rs_dest`=3. All busy → `rs_dest`=3'b111, `alloc_stall`=1.
- Stations 1 and 3 ready, `rr_ptr`=0, both FUs ready → next cycle FU0 `issue_sel`=1, FU1 `issue_sel`=3, `consumed_bus`=4'b1010, `rr_ptr`=0.
- All four stations held ready, both FUs always ready → issue pairs (0,1), (2,3), then (0,1) again after re-fill. Also check that no station is issued twice while its `pend` bit is set.
- `fu_ready`=2'b10 with only station 2 ready → FU1 receives 2, `issue_valid`=2'b10, FU0 idle.
- Station 0 consumed in cycle t+1 while `alloc_req` is high and station 1 is busy → `rs_dest` is not 0 in t+1, and is 0 in t+2.
- `mispredicted` pulse in the same cycle stations 0 and 1 become eligible → no issue the next cycle, `pend`=0, `rr_ptr` unchanged, `rs_dest`=3'b111 during the pulse.
